mul_unit: RTL

- Execute-stage RV64M multiply unit; sits between the decode/issue stage and the 128-bit iterative multiplier core `mALU`, which it instantiates.
- Accepts MUL/MULH/MULHSU/MULHU/MULW requests over a valid/ready handshake and conditions the operands into unsigned magnitudes.
- Fixes the final sign itself and selects the 64-bit result half.
- Holds a one-entry product cache so a MULH/MUL pair on the same operands costs one core pass.

---
 rtl/mul_pkg.sv | 47 ++++
 rtl/mul_unit_malu.sv | 86 ++++++++
 rtl/mul_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared types and helpers for the RV64M execute-stage multiply unit.
//   mul_op_e    : request opcode (req_op encoding)
//   mul_state_e : mul_unit control FSM states, codes 0..4
//   MUL_XLEN    : operand width (only 64 supported)
//   mul_select  : applies the final sign to an unsigned 128-bit product and
//                 picks the architectural 64-bit result
// -----------------------------------------------------------------------------
package mul_pkg;

   localparam int MUL_XLEN = 64;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BUSY  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } mul_state_e;

   // prod is |a|*|b|; negating the full 128 bits gives the signed product,
   // from which the low half, high half or sign-extended low word is taken.
   function automatic logic [63:0] mul_select(input logic [127:0] prod,
                                              input logic          neg,
                                              input mul_op_e       op,
                                              input logic          word);
      logic [127:0] p;
      logic [63:0]  res;
      p = neg ? (~prod + 128'd1) : prod;
      if (word)
         res = {{32{p[31]}}, p[31:0]};
      else if (op == MUL)
         res = p[63:0];
      else
         res = p[127:64];
      return res;
   endfunction

endpackage

// File: rtl/mul_unit_malu.sv
// -----------------------------------------------------------------------------
// mALU
// Iterative 64x64 -> 128-bit multiplier core, two multiplier bits per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : sampled only while idle; ignored while a pass runs
//   signed_a/signed_b : treat the matching operand as two's complement
//   a, b              : operands, sampled with start
//   ready             : one-cycle pulse when result is valid
//   result            : 128-bit product, held until the next start
// The edge that samples start also performs the first step; ready is high in
// the cycle that ends 34 edges after that sampling edge.
// -----------------------------------------------------------------------------
module mALU #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_a,
   input  logic              signed_b,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic              ready,
   output logic [2*XLEN-1:0] result
);

   localparam int STEPS = XLEN / 2;

   logic              busy;
   logic [5:0]        cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic              fix;
   logic [2*XLEN-1:0] a_ext;

   assign a_ext  = signed_a ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
   assign result = acc;

   function automatic logic [2*XLEN-1:0] pp(input logic [2*XLEN-1:0] mc,
                                            input logic [1:0]        bits);
      logic [2*XLEN-1:0] s;
      s = (bits[0] ? mc : '0) + (bits[1] ? (mc << 1) : '0);
      return s;
   endfunction

   // b is scanned as unsigned; a signed b with its top bit set is corrected
   // afterwards by subtracting a * 2^XLEN, which is exactly mcand once all
   // steps have shifted it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         fix    <= 1'b0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (!busy) begin
            if (start) begin
               acc    <= pp(a_ext, b[1:0]);
               mcand  <= a_ext << 2;
               mplier <= b >> 2;
               fix    <= signed_b & b[XLEN-1];
               cnt    <= 6'd1;
               busy   <= 1'b1;
            end
         end else if (cnt < 6'(STEPS)) begin
            acc    <= acc + pp(mcand, mplier[1:0]);
            mcand  <= mcand << 2;
            mplier <= mplier >> 2;
            cnt    <= cnt + 6'd1;
         end else if (cnt == 6'(STEPS)) begin
            if (fix)
               acc <= acc - mcand;
            cnt <= cnt + 6'd1;
         end else begin
            ready <= 1'b1;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
// RV64M execute-stage multiply unit (MUL/MULH/MULHSU/MULHU/MULW).
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_op, req_word        : opcode, MULW flag (MUL semantics on low word)
//   req_rs1, req_rs2, req_rd: operands and destination tag
//   flush                   : kill any accepted, unreturned request
//   resp_valid/resp_ready   : response handshake, held until taken
//   resp_data, resp_rd      : result and its tag
// Operands are reduced to magnitudes for the unsigned core; the sign is
// applied afterwards. A one-entry cache of the last core product lets a
// MULH/MUL pair on the same operands skip the second core pass.
// -----------------------------------------------------------------------------
module mul_unit
   import mul_pkg::*;
#(
   parameter int XLEN = MUL_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic            req_word,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic [4:0]      req_rd,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd
);

   mul_state_e        state;
   mul_op_e           op;
   mul_op_e           op_reg;
   logic              word_reg;
   logic              neg_reg;
   logic [4:0]        rd_reg;
   logic [XLEN-1:0]   mag_a_reg, mag_b_reg;

   logic              cache_valid;
   logic [XLEN-1:0]   cache_a, cache_b;
   logic [2*XLEN-1:0] cache_prod;

   logic              core_start;
   logic              core_ready;
   logic [2*XLEN-1:0] core_result;

   logic              sa, sb;
   logic [XLEN-1:0]   opa, opb;
   logic              a_neg, b_neg, neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              hit;

   // ---- operand conditioning (combinational, used at accept) ----
   assign op    = mul_op_e'(req_op);
   assign sa    = req_word | (op != MULHU);
   assign sb    = req_word | (op == MUL) | (op == MULH);
   assign opa   = req_word ? {{(XLEN-32){req_rs1[31]}}, req_rs1[31:0]} : req_rs1;
   assign opb   = req_word ? {{(XLEN-32){req_rs2[31]}}, req_rs2[31:0]} : req_rs2;
   assign a_neg = sa & opa[XLEN-1];
   assign b_neg = sb & opb[XLEN-1];
   assign neg   = a_neg ^ b_neg;
   // -(-2^63) wraps to 2^63, which is the correct unsigned magnitude.
   assign mag_a = a_neg ? (~opa + 1'b1) : opa;
   assign mag_b = b_neg ? (~opb + 1'b1) : opb;
   assign hit   = cache_valid && (cache_a == mag_a) && (cache_b == mag_b);

   assign req_ready  = (state == IDLE);
   assign core_start = (state == START);

   mALU #(.XLEN(XLEN)) u_malu (
      .clk      (clk),
      .rst      (rst),
      .start    (core_start),
      .signed_a (1'b0),
      .signed_b (1'b0),
      .a        (mag_a_reg),
      .b        (mag_b_reg),
      .ready    (core_ready),
      .result   (core_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_reg      <= MUL;
         word_reg    <= 1'b0;
         neg_reg     <= 1'b0;
         rd_reg      <= '0;
         mag_a_reg   <= '0;
         mag_b_reg   <= '0;
         cache_valid <= 1'b0;
         cache_a     <= '0;
         cache_b     <= '0;
         cache_prod  <= '0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_rd     <= '0;
      end else begin
         // Every core completion refreshes the cache, even one whose
         // request was flushed, so the work is not wasted.
         if (core_ready && (state == BUSY || state == DRAIN)) begin
            cache_valid <= 1'b1;
            cache_a     <= mag_a_reg;
            cache_b     <= mag_b_reg;
            cache_prod  <= core_result;
         end

         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  op_reg    <= op;
                  word_reg  <= req_word;
                  neg_reg   <= neg;
                  rd_reg    <= req_rd;
                  mag_a_reg <= mag_a;
                  mag_b_reg <= mag_b;
                  if (hit) begin
                     resp_valid <= 1'b1;
                     resp_data  <= mul_select(cache_prod, neg, op, req_word);
                     resp_rd    <= req_rd;
                     state      <= RESP;
                  end else begin
                     state <= START;
                  end
               end
            end
            // The core samples start on this edge regardless of flush, so a
            // flush here still has to wait out the pass.
            START: state <= flush ? DRAIN : BUSY;
            BUSY: begin
               if (core_ready) begin
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     resp_valid <= 1'b1;
                     resp_data  <= mul_select(core_result, neg_reg, op_reg, word_reg);
                     resp_rd    <= rd_reg;
                     state      <= RESP;
                  end
               end else if (flush) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (core_ready)
                  state <= IDLE;
            end
            RESP: begin
               if (flush || resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
